instr_issue_seq: RTL and testbench



---
 rtl/instr_issue_seq.sv | 152 +++++++++++++++
 tb/tb_instr_issue_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_seq.sv
// Issue-side sequencer for the DIN/Run/Done instruction handshake: walks addresses 0..LAST_ADDR,
// one Run strobe per instruction, halting on the last address, a Stop request or a Done timeout.
// Optional single-step mode (Step input, STEP_WAIT state) is enabled by defining SEQ_SINGLE_STEP_EN.
module instr_issue_seq #(
    parameter int ADDR_W    = 5,
    parameter int LAST_ADDR = 31,
    parameter int TIMEOUT   = 15
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Done,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic              Step,
`endif
    output logic              Run,
    output logic [ADDR_W-1:0] DIN,
    output logic              Busy,
    output logic              Halted,
    output logic              Timeout_err,
    output logic [7:0]        Issued_cnt,
    output logic [2:0]        dbg_state_o
);

    // Handshake: Run is a one-cycle strobe; DIN is stable from that strobe until Done is
    // sampled high in WAIT. Done seen while Run is high is ignored.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT      = 3'd2,
        S_NEXT      = 3'd3,
        S_HALT      = 3'd4,
        S_ERR       = 3'd5,
        S_STEP_WAIT = 3'd6
    } state_e;

    localparam logic [8:0]        TIMEOUT_C = 9'(TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST_C    = ADDR_W'(LAST_ADDR);

    state_e            state_q;
    logic [ADDR_W-1:0] din_q;
    logic              run_q;
    logic              busy_q;
    logic              halted_q;
    logic              err_q;
    logic              stop_q;
    logic [7:0]        cnt_q;
    logic [7:0]        timer_q;

    logic [7:0]        cnt_inc_d;
    logic [8:0]        timer_inc_d;
    logic [ADDR_W-1:0] din_inc_d;

    assign cnt_inc_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign timer_inc_d = {1'b0, timer_q} + 9'd1;
    assign din_inc_d   = din_q + ADDR_W'(1);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            din_q    <= '0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            stop_q   <= 1'b0;
            cnt_q    <= '0;
            timer_q  <= '0;
        end else begin
            run_q <= 1'b0;
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (Start) begin
                        state_q  <= S_ISSUE;
                        din_q    <= '0;
                        cnt_q    <= '0;
                        run_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                    timer_q <= '0;
                    if (Stop) stop_q <= 1'b1;
                end
                S_WAIT: begin
                    if (Stop) stop_q <= 1'b1;
                    // Done wins over a timeout expiring on the same edge.
                    if (Done) begin
                        cnt_q   <= cnt_inc_d;
                        state_q <= S_NEXT;
                    end else if (timer_inc_d == TIMEOUT_C) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        timer_q <= timer_inc_d[7:0];
                    end else begin
                        timer_q <= timer_inc_d[7:0];
                    end
                end
                S_NEXT: begin
                    // A Stop arriving in NEXT itself also halts: the instruction is already done.
                    if (stop_q || Stop || din_q == LAST_C) begin
                        state_q  <= S_HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        stop_q   <= 1'b0;
                    end else begin
                        din_q <= din_inc_d;
`ifdef SEQ_SINGLE_STEP_EN
                        state_q <= S_STEP_WAIT;
`else
                        state_q <= S_ISSUE;
                        run_q   <= 1'b1;
`endif
                    end
                end
`ifdef SEQ_SINGLE_STEP_EN
                S_STEP_WAIT: begin
                    if (Stop) begin
                        state_q  <= S_HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        stop_q   <= 1'b0;
                    end else if (Step) begin
                        state_q <= S_ISSUE;
                        run_q   <= 1'b1;
                    end
                end
`endif
                S_ERR: begin
                    state_q <= S_ERR;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Run         = run_q;
    assign DIN         = din_q;
    assign Busy        = busy_q;
    assign Halted      = halted_q;
    assign Timeout_err = err_q;
    assign Issued_cnt  = cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_issue_seq.sv
// Self-checking bench for instr_issue_seq: random Done latencies, Stop, timeout and reset
// scenarios, checked against expected address queues and issue-period arithmetic.
module tb_instr_issue_seq;

    localparam int ADDR_W = 5;
    localparam int LAST   = 6;
    localparam int TO     = 15;

    logic              clk    = 1'b0;
    logic              rst_n  = 1'b0;
    logic              start  = 1'b0;
    logic              stop   = 1'b0;
    logic              done   = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    logic              step   = 1'b0;
`endif
    logic              run;
    logic [ADDR_W-1:0] din;
    logic              busy;
    logic              halted;
    logic              tmo;
    logic [7:0]        cnt;
    logic [2:0]        dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [ADDR_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    instr_issue_seq #(
        .ADDR_W   (ADDR_W),
        .LAST_ADDR(LAST),
        .TIMEOUT  (TO)
    ) dut (
        .Clock      (clk),
        .Resetn     (rst_n),
        .Start      (start),
        .Stop       (stop),
        .Done       (done),
`ifdef SEQ_SINGLE_STEP_EN
        .Step       (step),
`endif
        .Run        (run),
        .DIN        (din),
        .Busy       (busy),
        .Halted     (halted),
        .Timeout_err(tmo),
        .Issued_cnt (cnt),
        .dbg_state_o(dbg_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_run"}, 32'(run), 32'd0);
        check_eq({tag, "_din"}, 32'(din), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_halted"}, 32'(halted), 32'd0);
        check_eq({tag, "_tmo"}, 32'(tmo), 32'd0);
        check_eq({tag, "_cnt"}, 32'(cnt), 32'd0);
    endtask

    // Asynchronous reset: outputs must clear within the same half cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_now");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int expected_last(input int stop_at);
        return (stop_at >= 0 && stop_at < LAST) ? stop_at : LAST;
    endfunction

    // Halted/idle idling: Stop and missing Start must not issue anything.
    task automatic idle_check(input int n, input int exp_halted, input int exp_din);
        for (int i = 0; i < n; i++) begin
            stop = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("idle_run", 32'(run), 32'd0);
            check_eq("idle_busy", 32'(busy), 32'd0);
            check_eq("idle_halted", 32'(halted), 32'(exp_halted));
            check_eq("idle_din", 32'(din), 32'(exp_din));
        end
        stop = 1'b0;
    endtask

    // Runs one program from Start. Caller is at a negedge with the DUT idle or halted.
    // stop_at/to_at/rst_at select the address where Stop, a missing Done, or a reset occurs.
    task automatic run_program(input int stop_at, input int to_at, input int rst_at,
                               input bit noisy, input int k_fix, input int step_stop_at);
        int last;
        int k;
        int sj;
        int rj;
        int addr;
        int n_steps;
        int cnt_exp;
        last = expected_last(stop_at);
        if (to_at >= 0 && to_at < last) last = to_at;
        if (rst_at >= 0 && rst_at < last) last = rst_at;
        exp_q.delete();
        for (int a = 0; a <= last; a++) exp_q.push_back(ADDR_W'(a));
        cnt_exp = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (exp_q.size() > 0) begin
            addr = int'(exp_q.pop_front());
            check_eq("issue_run", 32'(run), 32'd1);
            check_eq("issue_din", 32'(din), 32'(addr));
            check_eq("issue_busy", 32'(busy), 32'd1);
            check_eq("issue_halted", 32'(halted), 32'd0);
            check_eq("issue_cnt", 32'(cnt), 32'(cnt_exp));
            if (addr == to_at) begin
                for (int j = 1; j <= TO; j++) begin
                    @(negedge clk);
                    check_eq("to_wait_run", 32'(run), 32'd0);
                    check_eq("to_wait_busy", 32'(busy), 32'd1);
                    check_eq("to_wait_tmo", 32'(tmo), 32'd0);
                    check_eq("to_wait_din", 32'(din), 32'(addr));
                end
                @(negedge clk);
                check_eq("err_tmo", 32'(tmo), 32'd1);
                check_eq("err_busy", 32'(busy), 32'd0);
                check_eq("err_run", 32'(run), 32'd0);
                check_eq("err_halted", 32'(halted), 32'd0);
                start = 1'b1;
                stop  = 1'b1;
                @(negedge clk);
                start = 1'b0;
                stop  = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    check_eq("err_sticky_tmo", 32'(tmo), 32'd1);
                    check_eq("err_start_run", 32'(run), 32'd0);
                    check_eq("err_start_busy", 32'(busy), 32'd0);
                    @(negedge clk);
                end
                return;
            end
            k  = (k_fix > 0) ? k_fix : $urandom_range(1, TO);
            sj = (addr == stop_at) ? $urandom_range(0, k) : -1;
            rj = (addr == rst_at) ? $urandom_range(1, k) : -1;
            stop = (sj == 0);
            for (int j = 1; j <= k; j++) begin
                @(negedge clk);
                check_eq("wait_run", 32'(run), 32'd0);
                check_eq("wait_din", 32'(din), 32'(addr));
                check_eq("wait_busy", 32'(busy), 32'd1);
                check_eq("wait_tmo", 32'(tmo), 32'd0);
                if (j == rj) begin
                    stop  = 1'b0;
                    start = 1'b0;
                    do_reset();
                    for (int i = 0; i < 4; i++) begin
                        done = 1'(i % 2);
                        @(negedge clk);
                        check_eq("postrst_run", 32'(run), 32'd0);
                        check_eq("postrst_busy", 32'(busy), 32'd0);
                        check_eq("postrst_cnt", 32'(cnt), 32'd0);
                        check_eq("postrst_din", 32'(din), 32'd0);
                    end
                    done = 1'b0;
                    return;
                end
                stop = (j == sj);
                done = (j == k);
                if (noisy) start = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            done  = 1'b0;
            stop  = 1'b0;
            start = 1'b0;
            cnt_exp = (cnt_exp == 255) ? 255 : cnt_exp + 1;
            check_eq("next_cnt", 32'(cnt), 32'(cnt_exp));
            check_eq("next_run", 32'(run), 32'd0);
            check_eq("next_busy", 32'(busy), 32'd1);
            check_eq("next_din", 32'(din), 32'(addr));
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check_eq("halt_halted", 32'(halted), 32'd1);
                check_eq("halt_busy", 32'(busy), 32'd0);
                check_eq("halt_run", 32'(run), 32'd0);
                check_eq("halt_din", 32'(din), 32'(addr));
                check_eq("halt_cnt", 32'(cnt), 32'(cnt_exp));
            end else begin
`ifdef SEQ_SINGLE_STEP_EN
                n_steps = $urandom_range(1, 10);
                for (int i = 0; i < n_steps; i++) begin
                    check_eq("step_run", 32'(run), 32'd0);
                    check_eq("step_busy", 32'(busy), 32'd1);
                    check_eq("step_din", 32'(din), 32'(addr + 1));
                    check_eq("step_halted", 32'(halted), 32'd0);
                    if (i == n_steps - 1) begin
                        if (addr + 1 == step_stop_at) stop = 1'b1;
                        else step = 1'b1;
                    end
                    @(negedge clk);
                end
                step = 1'b0;
                if (addr + 1 == step_stop_at) begin
                    stop = 1'b0;
                    check_eq("stepstop_halted", 32'(halted), 32'd1);
                    check_eq("stepstop_busy", 32'(busy), 32'd0);
                    check_eq("stepstop_run", 32'(run), 32'd0);
                    check_eq("stepstop_din", 32'(din), 32'(addr + 1));
                    check_eq("stepstop_cnt", 32'(cnt), 32'(cnt_exp));
                    return;
                end
`else
                n_steps = step_stop_at;
`endif
            end
        end
    endtask

    initial begin
        int choice;
        int pick;
        @(negedge clk);
        check_all_zero("reset");
        check_eq("reset_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        idle_check(3, 0, 0);

        run_program(-1, -1, -1, 1'b0, 1, -1);
        idle_check(3, 1, LAST);
        run_program(-1, -1, -1, 1'b0, TO, -1);
        run_program(-1, -1, -1, 1'b1, 4, -1);
        run_program(2, -1, -1, 1'b0, 0, -1);
        idle_check(3, 1, 2);
        run_program(-1, 3, -1, 1'b1, 0, -1);
        do_reset();
        run_program(-1, -1, 5, 1'b0, 0, -1);
`ifdef SEQ_SINGLE_STEP_EN
        run_program(-1, -1, -1, 1'b0, 1, 3);
        idle_check(2, 1, 3);
`endif

        for (int it = 0; it < 14; it++) begin
            choice = $urandom_range(0, 3);
            pick   = $urandom_range(0, LAST);
            case (choice)
                0: run_program(-1, -1, -1, 1'b1, 0, -1);
                1: begin
                    run_program(pick, -1, -1, 1'b1, 0, -1);
                    idle_check(2, 1, expected_last(pick));
                end
                2: begin
                    run_program(-1, pick, -1, 1'b1, 0, -1);
                    do_reset();
                end
                default: run_program(-1, -1, pick, 1'b0, 0, -1);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
